// File: rtl/mux4_arb_pkg.sv
// Shared constants and helpers for the 4-requester round-robin mux arbiter.
//   NUM_REQ   : number of requesters
//   SEL_W     : width of a requester index
//   PTR_RESET : last-grant pointer after reset (requester 0 wins first)
//   onehot4() : index -> 4-bit one-hot grant vector
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] PTR_RESET = 2'd3;

  // Index to one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
// Scans (ptr+1), (ptr+2), (ptr+3), ptr (all mod 4) and returns the first
// index whose req bit is set.
//   req    : request vector
//   ptr    : last-granted index; the search starts just after it
//   winner : selected index (equals ptr when nothing requests)
//   any    : at least one request is present
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  // Walk from the farthest candidate back to the nearest so the nearest
  // requesting index is the last (and therefore final) assignment.
  always_comb begin
    winner = ptr;
    any    = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[SEL_W'(ptr + SEL_W'(k))]) begin
        winner = SEL_W'(ptr + SEL_W'(k));
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters,
// with a registered valid/ready output stage (one transfer per cycle when
// the sink is ready).
// Optional burst mode: define MUX4_ARB_BURST_EN to let the previous winner
// keep priority for up to MAX_BURST consecutive captures.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester valid
//   a,b,c,d    : requester 0..3 data
//   ack        : one-hot capture strobe (combinational)
//   out_valid  : out_data holds an untransferred word
//   out_ready  : sink accepts when out_valid & out_ready
//   out_data   : captured word (registered)
//   out_sel    : index that produced out_data (registered)
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
`ifdef MUX4_ARB_BURST_EN
  ,
  parameter int unsigned MAX_BURST = 4
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [WIDTH-1:0]    c,
  input  logic [WIDTH-1:0]    d,
  output logic [NUM_REQ-1:0]  ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_sel
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_winner;
  logic             rr_any;
  logic [SEL_W-1:0] winner;
  logic             load;
  logic [WIDTH-1:0] mux_data;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (rr_winner),
    .any    (rr_any)
  );

`ifdef MUX4_ARB_BURST_EN
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] burst_cnt;
  logic             hold;

  // Previous winner keeps the slot while it still requests and its burst
  // budget is not spent; otherwise fall back to plain rotation from ptr.
  assign hold   = req[ptr] && (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));
  assign winner = hold ? ptr : rr_winner;

  // Burst length tracker; restarts at 1 whenever the slot was won by rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (load) begin
      burst_cnt <= hold ? CNT_W'(burst_cnt + CNT_W'(1)) : CNT_W'(1);
    end else if (!rr_any) begin
      burst_cnt <= '0;
    end
  end
`else
  assign winner = rr_winner;
`endif

  // Capture when something requests and the output slot is free or draining.
  assign load = rst_n && rr_any && (!out_valid || out_ready);
  assign ack  = load ? onehot4(winner) : '0;

  // Shared 4:1 data mux steered by the scheduler.
  always_comb begin
    mux_data = a;
    case (winner)
      2'd0:    mux_data = a;
      2'd1:    mux_data = b;
      2'd2:    mux_data = c;
      default: mux_data = d;
    endcase
  end

  // Output stage and last-grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= PTR_RESET;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= winner;
      ptr       <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed steps followed by
// randomized traffic, compared against a behavioural model of the
// arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int unsigned W = 4;
`ifdef MUX4_ARB_BURST_EN
  localparam int MB = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] a, b, c, d;
  logic [3:0]   ack;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_cnt;

  always #5 clk = ~clk;

`ifdef MUX4_ARB_BURST_EN
  mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
`else
  mux4_rr_arbiter #(.WIDTH(W)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 3;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_cnt   = 0;
  endtask

  // Winning index for the current inputs, or -1 if nobody requests.
  function automatic int m_win();
    int w;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
`ifdef MUX4_ARB_BURST_EN
    if (m_cnt > 0 && m_cnt < MB && req[m_ptr]) w = m_ptr;
`endif
    return w;
  endfunction

  function automatic bit m_load();
    return (req != 4'b0000) && (!m_valid || out_ready);
  endfunction

  function automatic logic [3:0] m_ack();
    if (!m_load()) return 4'b0000;
    return 4'(1 << m_win());
  endfunction

  // One clock: check ack before the edge, advance the model, check outputs after.
  task automatic cycle(input string tag);
    int           w;
    bit           ld;
    logic [W-1:0] din [4];
    #1;
    chk({tag, ".ack"}, 32'(ack), 32'(m_ack()));
    w  = m_win();
    ld = m_load();
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    @(posedge clk);
    if (ld) begin
      if (w == m_ptr && m_cnt > 0 && m_cnt < 4'hF) m_cnt = m_cnt + 1;
      else m_cnt = 1;
`ifdef MUX4_ARB_BURST_EN
      if (m_cnt > MB) m_cnt = 1;
`endif
      m_data  = din[w];
      m_sel   = w;
      m_valid = 1'b1;
      m_ptr   = w;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (req == 4'b0000) m_cnt = 0;
    end
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(out_data),  32'(m_data));
    chk({tag, ".sel"},   32'(out_sel),   32'(m_sel));
    @(negedge clk);
  endtask

  initial begin
    // Reset with requests pending: no ack, cleared outputs.
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    model_reset();
    #12;
    chk("rst.ack",   32'(ack),       32'h0);
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.data",  32'(out_data),  32'h0);
    chk("rst.sel",   32'(out_sel),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 0.
    req = 4'b0001; a = 4'hA; out_ready = 1'b1;
    cycle("t1");
    chk("t1.data_a", 32'(out_data), 32'hA);

    // All requesting: strict rotation, back-to-back.
    req = 4'b1111; a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
    for (int i = 0; i < 5; i++) cycle("t2");

    // Backpressure then release.
    req = 4'b0110; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t3.bp");
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) cycle("t3.go");

    // Asynchronous reset mid-cycle while holding a word.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.valid", 32'(out_valid), 32'h0);
    chk("t5.data",  32'(out_data),  32'h0);
    chk("t5.ack",   32'(ack),       32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100; c = 4'h7;
    cycle("t5.rel");
    chk("t5.sel2", 32'(out_sel), 32'h2);

    // Wrap-around from ptr=2 with req=1001.
    req = 4'b1001;
    cycle("t4.a");
    chk("t4.sel3", 32'(out_sel), 32'h3);
    cycle("t4.b");
    chk("t4.sel0", 32'(out_sel), 32'h0);

    // Two-requester pattern (exercises bursts when enabled).
    req = 4'b0000;
    cycle("t6.idle");
    req = 4'b0011;
    for (int i = 0; i < 6; i++) cycle("t6");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom % 4) != 0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 data mux between four requesters, each with its own valid/ack handshake.
- A round-robin scheduler drives the mux select and captures the winning input into a registered output stage.
- The output stage has a valid/ready handshake.
- Sits in front of any shared 4:1 datapath consumer; sustains one transfer per cycle when the sink is ready.

Parameters:
- WIDTH, 4, data width of each requester input and of out_data.
- MAX_BURST, 4, maximum consecutive captures from one requester; used only when MUX4_ARB_BURST_EN is defined; legal 1..15.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  req[i] = requester i has valid data on its input.
- a  input  WIDTH  requester 0 data.
- b  input  WIDTH  requester 1 data.
- c  input  WIDTH  requester 2 data.
- d  input  WIDTH  requester 3 data.
- ack  output  4  one-hot, combinational; ack[i]=1 means requester i's data is captured at this edge.
- out_valid  output  1  out_data holds an untransferred word.
- out_ready  input  1  sink accepts when out_valid & out_ready.
- out_data  output  WIDTH  captured word; registered.
- out_sel  output  2  index of the requester that produced out_data; registered.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Last-grant pointer ptr=3, so requester 0 wins first.
  - Burst counter=0.
  - ack=0 while in reset.
- load = |req & (!out_valid | out_ready).
- Winner: first i with req[i]=1, scanning (ptr+1) mod 4, (ptr+2) mod 4, ... with wrap-around.
- ack = load ? onehot(winner) : 4'b0000. ack depends only on req, out_valid, out_ready and state; never on the data inputs.
- On a clock edge with load=1:
  - out_data <= input[winner], out_sel <= winner, out_valid <= 1, ptr <= winner.
- On an edge with out_valid & out_ready & !load: out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and capture (out_valid & out_ready & |req): new word is loaded and out_valid stays 1. This gives back-to-back throughput.
- Backpressure (out_valid & !out_ready): ack=0; out_data and out_sel are stable.
- Latency: req/data sampled at edge N gives out_valid=1 from N+1.
- Requester contract:
  - Holds req and data stable until it sees ack.
  - May change data or drop req in the cycle after ack.
  - Dropping req without ack is legal; no capture occurs.
- Fairness: without burst, any continuously asserting requester is served within 4 captures.
- ptr wraps 3 -> 0 modulo 4.
- req=0000: no capture and ptr unchanged.
- Reset mid-transfer discards the held word; there is no recovery handshake.

Optional Feature:
- Macro: MUX4_ARB_BURST_EN.
- Defined:
  - The winner of the previous capture keeps priority while its req stays high, up to MAX_BURST consecutive captures.
  - The burst counter increments per capture from the same index and resets to 1 on a capture from a new index.
  - At MAX_BURST, normal round-robin from ptr applies for the next capture.
  - The counter clears on an idle cycle with no capture.
- Undefined: strict rotation every capture; MAX_BURST and the counter are absent.

Decomposition:
- Package mux4_arb_pkg:
  - NUM_REQ=4, SEL_W=2.
  - PTR_RESET=2'd3.
  - Function onehot4(sel) returning a 4-bit one-hot.
- Sub-module rr_pick4: combinational rotating priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: winner[1:0], any.
  - Instantiated once; reused by the burst override logic.

Test Plan:
1. Reset, then req=0001, a=4'hA, out_ready=1 -> ack=0001 in that cycle; next cycle out_valid=1, out_data=A, out_sel=0.
2. req=1111 held with a..d = 1,2,3,4, out_ready=1, burst off -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_valid stays 1 throughout.
3. Word held with out_ready=0 for 3 cycles and req=0110 -> ack=0000 and out_data/out_sel stable. Raise out_ready -> drain and capture in the same edge, then out_sel=1 then 2.
4. ptr=2 and req=1001 -> winner 3; next capture with req=1001 -> winner 0 (wrap-around).
5. rst_n pulled low asynchronously mid-cycle while out_valid=1 -> out_valid, out_data and ack go to 0 immediately; after release with req=0100, out_sel=2 and ptr=2.
6. MUX4_ARB_BURST_EN defined, MAX_BURST=2, req=0011 held -> out_sel sequence 0,0,1,1,0,0.
